// File: rtl/hienthi_ngaygio_nhapnhay_pkg.sv
// Shared constants for the date/time 7-segment display: active-low glyphs
// (bit order g,f,e,d,c,b,a) and a width helper that never returns zero.
package hienthi_ngaygio_nhapnhay_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Bits needed to hold 0..n-1, at least 1 so degenerate sizes still compile.
   function automatic int unsigned safe_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hienthi_ngaygio_nhapnhay_giai_ma_bcd_7doan.sv
// One BCD nibble to an active-low 7-segment pattern; non-decimal codes show '-'.
module giai_ma_bcd_7doan
   import hienthi_ngaygio_nhapnhay_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      if (blank_i) begin
         seg_c = SEG_BLANK;
      end else begin
         case (nibble_i)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/hienthi_ngaygio_nhapnhay.sv
// Two-page BCD date/time display with edit-field blinking, leading-zero
// blanking, static per-digit segment outputs and a scanned digit bus.
module hienthi_ngaygio_nhapnhay
   import hienthi_ngaygio_nhapnhay_pkg::*;
#(
   parameter int unsigned           NUM_FIELDS = 3,
   parameter int unsigned           BLINK_DIV  = 25000000,
   parameter int unsigned           SCAN_DIV   = 50000,
   parameter logic [NUM_FIELDS-1:0] LZB_MASK   = 3'b011,
   parameter bit                    ACTIVE_LOW = 1'b1
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [8*NUM_FIELDS-1:0]         page_a,
   input  logic [8*NUM_FIELDS-1:0]         page_b,
   input  logic                            page_sel,
   input  logic                            edit_en,
   input  logic [safe_w(NUM_FIELDS)-1:0]   edit_field,
   output logic [14*NUM_FIELDS-1:0]        seg_static,
   output logic [6:0]                      seg_mux,
   output logic [2*NUM_FIELDS-1:0]         dig_sel
);

   localparam int unsigned ND = 2 * NUM_FIELDS;
   localparam int unsigned FW = safe_w(NUM_FIELDS);
   localparam int unsigned BW = safe_w(BLINK_DIV);
   localparam int unsigned SW = safe_w(SCAN_DIV);
   localparam int unsigned IW = safe_w(ND);
   localparam logic [6:0]  POL_MASK  = ACTIVE_LOW ? 7'h00 : 7'h7F;
   localparam logic [6:0]  BLANK_OUT = SEG_BLANK ^ POL_MASK;

   logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
   logic               blink_phase_q, blink_phase_d;
   logic               edit_en_q;
   logic [FW-1:0]      edit_field_q;
   logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]      scan_idx_q, scan_idx_d;
   logic [7*ND-1:0]    seg_static_q, seg_static_d;
   logic [6:0]         seg_mux_q, seg_mux_d;
   logic [ND-1:0]      dig_sel_q, dig_sel_d;

   logic               blink_clr_c;
   logic [8*NUM_FIELDS-1:0] page_c;
   logic [3:0]         nib_c [ND];
   logic               blk_c [ND];
   logic [6:0]         seg_raw_c [ND];

   // Blink timer; a fresh edit target restarts in the visible phase.
   always_comb begin
      blink_clr_c   = edit_en && (!edit_en_q || (edit_field != edit_field_q));
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;
      if (blink_clr_c) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_d   = '0;
         blink_phase_d = !blink_phase_q;
      end
   end

   // Per-digit nibble and blank selection; uses the post-clear blink phase.
   always_comb begin
      page_c = page_sel ? page_b : page_a;
      for (int i = 0; i < int'(NUM_FIELDS); i++) begin
         nib_c[2*i]   = page_c[8*i +: 4];
         nib_c[2*i+1] = page_c[8*i+4 +: 4];
         blk_c[2*i]   = edit_en && (edit_field == FW'(i)) && blink_phase_d;
         blk_c[2*i+1] = blk_c[2*i] || (LZB_MASK[i] && (page_c[8*i+4 +: 4] == 4'd0));
      end
   end

   for (genvar d = 0; d < int'(ND); d++) begin : g_dec
      giai_ma_bcd_7doan u_dec (
         .nibble_i (nib_c[d]),
         .blank_i  (blk_c[d]),
         .seg_c    (seg_raw_c[d])
      );
   end

   always_comb begin
      for (int d = 0; d < int'(ND); d++) begin
         seg_static_d[7*d +: 7] = seg_raw_c[d] ^ POL_MASK;
      end
   end

   // Scan position; seg_mux is picked from the same next-state as dig_sel.
   always_comb begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IW'(ND - 1)) ? '0 : scan_idx_q + IW'(1);
      end
      dig_sel_d = ND'(1) << scan_idx_d;
      seg_mux_d = BLANK_OUT;
      for (int d = 0; d < int'(ND); d++) begin
         if (scan_idx_d == IW'(d)) seg_mux_d = seg_static_d[7*d +: 7];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         edit_en_q     <= 1'b0;
         edit_field_q  <= '0;
         scan_cnt_q    <= '0;
         scan_idx_q    <= '0;
         seg_static_q  <= {ND{BLANK_OUT}};
         seg_mux_q     <= BLANK_OUT;
         dig_sel_q     <= ND'(1);
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         edit_en_q     <= edit_en;
         edit_field_q  <= edit_field;
         scan_cnt_q    <= scan_cnt_d;
         scan_idx_q    <= scan_idx_d;
         seg_static_q  <= seg_static_d;
         seg_mux_q     <= seg_mux_d;
         dig_sel_q     <= dig_sel_d;
      end
   end

   assign seg_static = seg_static_q;
   assign seg_mux    = seg_mux_q;
   assign dig_sel    = dig_sel_q;

endmodule
